// File: rtl/proj_pkg.sv
// -----------------------------------------------------------------------------
// proj_pkg
//   Shared constants and types for the feature-memory (FM) blocks.
//   FM_* localparams give the default geometry of the multi-buffer FM:
//   buffers in rotation, RAM banks per buffer, entries per RAM, bytes per
//   entry, genome byte width and bytes returned per read.
//   fm_addr_t addresses one byte inside a buffer; fm_len_t holds a buffer
//   length (1..FM_BUF_BYTES).
// -----------------------------------------------------------------------------
package proj_pkg;

   localparam int FM_BUFFER_COUNT       = 3;
   localparam int FM_RAMS_COUNT         = 4;
   localparam int FM_ENTRIES_COUNT      = 16;
   localparam int FM_OFFSET_COUNT       = 4;
   localparam int FM_GENOME_BTYE        = 8;
   localparam int FM_ADDRESS_READ_COUNT = 4;

   localparam int FM_BUF_BYTES = FM_RAMS_COUNT * FM_ENTRIES_COUNT * FM_OFFSET_COUNT;
   localparam int FM_AW        = $clog2(FM_BUF_BYTES);
   localparam int FM_CW        = $clog2(FM_BUFFER_COUNT + 1);

   typedef logic [FM_AW-1:0] fm_addr_t;
   typedef logic [FM_AW:0]   fm_len_t;

endpackage

// File: rtl/proj_fm_mbuf_if.sv
// -----------------------------------------------------------------------------
// proj_fm_mbuf_if
//   Bundle of the FM write stream, read request/response, release and status
//   signals. master = genome loader / window logic side, slave = the FM.
//   Write : in_wvalid, in_wdata, in_wlast  -> out_wready
//   Read  : in_rvalid, in_raddr            -> out_rready, out_rdata,
//                                             out_rdata_valid, out_rlen
//   Other : in_rdone (release head buffer), out_fill_cnt, out_stall_cnt
// -----------------------------------------------------------------------------
interface proj_fm_mbuf_if
   import proj_pkg::*;
#(
   parameter int DATA_BITS            = FM_GENOME_BTYE,
   parameter int AW                   = FM_AW,
   parameter int READ_ADDRESSES_COUNT = FM_ADDRESS_READ_COUNT,
   parameter int CW                   = FM_CW
);

   logic                                      in_wvalid;
   logic [DATA_BITS-1:0]                      in_wdata;
   logic                                      in_wlast;
   logic                                      out_wready;
   logic                                      in_rvalid;
   logic [AW-1:0]                             in_raddr;
   logic                                      out_rready;
   logic [READ_ADDRESSES_COUNT*DATA_BITS-1:0] out_rdata;
   logic                                      out_rdata_valid;
   logic [AW:0]                               out_rlen;
   logic                                      in_rdone;
   logic [CW-1:0]                             out_fill_cnt;
   logic [15:0]                               out_stall_cnt;

   modport master (
      output in_wvalid, in_wdata, in_wlast, in_rvalid, in_raddr, in_rdone,
      input  out_wready, out_rready, out_rdata, out_rdata_valid, out_rlen,
             out_fill_cnt, out_stall_cnt
   );

   modport slave (
      input  in_wvalid, in_wdata, in_wlast, in_rvalid, in_raddr, in_rdone,
      output out_wready, out_rready, out_rdata, out_rdata_valid, out_rlen,
             out_fill_cnt, out_stall_cnt
   );

endinterface

// File: rtl/proj_fm_buf_bank.sv
// -----------------------------------------------------------------------------
// proj_fm_buf_bank
//   Storage for one FM buffer: RAMS banks x ENTRIES entries x OFFSET lanes.
//   Byte address a -> bank a/(ENTRIES*OFFSET), entry (a/OFFSET)%ENTRIES,
//   lane a%OFFSET; with power-of-two geometry these are plain bit fields.
//   Ports:
//     clk_i      write clock
//     we_i       write one byte at waddr_i
//     waddr_i    byte address, wdata_i byte
//     raddr_i    start of the read window
//     rwin_o     READ_ADDRESSES_COUNT bytes starting at raddr_i, wrapping at
//                the buffer end; byte k at [k*DATA_BITS +: DATA_BITS]
//   RAMS, ENTRIES and OFFSET must be powers of two, each >= 2.
// -----------------------------------------------------------------------------
module proj_fm_buf_bank #(
   parameter int RAMS                 = 4,
   parameter int ENTRIES              = 16,
   parameter int OFFSET               = 4,
   parameter int DATA_BITS            = 8,
   parameter int READ_ADDRESSES_COUNT = 4,
   parameter int AW                   = $clog2(RAMS * ENTRIES * OFFSET)
) (
   input  logic                                      clk_i,
   input  logic                                      we_i,
   input  logic [AW-1:0]                             waddr_i,
   input  logic [DATA_BITS-1:0]                      wdata_i,
   input  logic [AW-1:0]                             raddr_i,
   output logic [READ_ADDRESSES_COUNT*DATA_BITS-1:0] rwin_o
);

   localparam int LW = $clog2(OFFSET);
   localparam int EW = $clog2(ENTRIES);

   logic [DATA_BITS-1:0] mem_q [RAMS][ENTRIES][OFFSET];

   // NOTE: storage arrays get no reset; their contents are only meaningful
   // once written, and a reset port would prevent RAM inference.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i[AW-1:LW+EW]][waddr_i[LW+EW-1:LW]][waddr_i[LW-1:0]] <= wdata_i;
      end
   end

   // The AW-bit sum wraps naturally at the buffer end, and each byte picks its
   // own bank, so windows spanning a bank boundary need no special casing.
   for (genvar k = 0; k < READ_ADDRESSES_COUNT; k++) begin : g_win
      logic [AW-1:0] a;
      assign a = raddr_i + AW'(k);
      assign rwin_o[k*DATA_BITS +: DATA_BITS] = mem_q[a[AW-1:LW+EW]][a[LW+EW-1:LW]][a[LW-1:0]];
   end

endmodule

// File: rtl/proj_fm_mbuf.sv
// -----------------------------------------------------------------------------
// proj_fm_mbuf
//   Multi-buffer feature memory. Genome bytes fill BUFFER_COUNT buffers
//   round-robin; the consumer reads READ_ADDRESSES_COUNT-byte windows from the
//   oldest full buffer and releases it with in_rdone.
//   Ports:
//     in_clk, in_rst_n   clock, asynchronous active-low reset
//     bus (slave)        write stream, read request/response, release and
//                        status (see proj_fm_mbuf_if)
//   Optional: define PROJ_FM_STALL_CNT_EN to count cycles in which a write is
//   offered but refused (saturating 16-bit); otherwise out_stall_cnt is 0.
// -----------------------------------------------------------------------------
module proj_fm_mbuf
   import proj_pkg::*;
#(
   parameter int BUFFER_COUNT         = FM_BUFFER_COUNT,
   parameter int RAMS                 = FM_RAMS_COUNT,
   parameter int ENTRIES              = FM_ENTRIES_COUNT,
   parameter int OFFSET               = FM_OFFSET_COUNT,
   parameter int DATA_BITS            = FM_GENOME_BTYE,
   parameter int READ_ADDRESSES_COUNT = FM_ADDRESS_READ_COUNT
) (
   input  logic          in_clk,
   input  logic          in_rst_n,
   proj_fm_mbuf_if.slave bus
);

   localparam int BUF_BYTES = RAMS * ENTRIES * OFFSET;
   localparam int AW        = $clog2(BUF_BYTES);
   localparam int CW        = $clog2(BUFFER_COUNT + 1);
   localparam int IW        = $clog2(BUFFER_COUNT);
   localparam int WW        = READ_ADDRESSES_COUNT * DATA_BITS;

   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic [IW-1:0] rd_idx_q, rd_idx_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] fill_cnt_q, fill_cnt_d;
   logic [AW:0]   len_q [BUFFER_COUNT];
   logic [WW-1:0] rdata_q;
   logic          rdata_valid_q;
   logic [WW-1:0] win [BUFFER_COUNT];

   logic wready, wr_acc, close, rd_acc, rel;

   // NOTE: every signal driven here gets a default first, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      wready = fill_cnt_q < CW'(BUFFER_COUNT);
      wr_acc = bus.in_wvalid && wready;
      close  = wr_acc && (bus.in_wlast || wr_ptr_q == AW'(BUF_BYTES - 1));
      rd_acc = bus.in_rvalid && fill_cnt_q != '0;
      rel    = bus.in_rdone && fill_cnt_q != '0;

      wr_ptr_d   = wr_ptr_q;
      wr_idx_d   = wr_idx_q;
      rd_idx_d   = rd_idx_q;
      fill_cnt_d = fill_cnt_q;

      if (wr_acc) begin
         if (close) begin
            wr_ptr_d = '0;
            wr_idx_d = (wr_idx_q == IW'(BUFFER_COUNT - 1)) ? '0 : wr_idx_q + IW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
      end

      if (rel) begin
         rd_idx_d = (rd_idx_q == IW'(BUFFER_COUNT - 1)) ? '0 : rd_idx_q + IW'(1);
      end

      // A close and a release in the same cycle cancel out.
      case ({close, rel})
         2'b10:   fill_cnt_d = fill_cnt_q + CW'(1);
         2'b01:   fill_cnt_d = fill_cnt_q - CW'(1);
         default: fill_cnt_d = fill_cnt_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         wr_idx_q      <= '0;
         rd_idx_q      <= '0;
         wr_ptr_q      <= '0;
         fill_cnt_q    <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         for (int b = 0; b < BUFFER_COUNT; b++) len_q[b] <= '0;
      end else begin
         wr_idx_q      <= wr_idx_d;
         rd_idx_q      <= rd_idx_d;
         wr_ptr_q      <= wr_ptr_d;
         fill_cnt_q    <= fill_cnt_d;
         rdata_valid_q <= rd_acc;
         // The read uses the pre-release rd_idx_q even when in_rdone is high.
         if (rd_acc) rdata_q <= win[rd_idx_q];
         if (close) len_q[wr_idx_q] <= {1'b0, wr_ptr_q} + (AW + 1)'(1);
      end
   end

   for (genvar b = 0; b < BUFFER_COUNT; b++) begin : g_bank
      proj_fm_buf_bank #(
         .RAMS                 (RAMS),
         .ENTRIES              (ENTRIES),
         .OFFSET               (OFFSET),
         .DATA_BITS            (DATA_BITS),
         .READ_ADDRESSES_COUNT (READ_ADDRESSES_COUNT),
         .AW                   (AW)
      ) u_bank (
         .clk_i   (in_clk),
         .we_i    (wr_acc && wr_idx_q == IW'(b)),
         .waddr_i (wr_ptr_q),
         .wdata_i (bus.in_wdata),
         .raddr_i (bus.in_raddr),
         .rwin_o  (win[b])
      );
   end

   assign bus.out_wready      = wready;
   assign bus.out_rready      = fill_cnt_q != '0;
   assign bus.out_rdata       = rdata_q;
   assign bus.out_rdata_valid = rdata_valid_q;
   assign bus.out_rlen        = (fill_cnt_q != '0) ? len_q[rd_idx_q] : '0;
   assign bus.out_fill_cnt    = fill_cnt_q;

`ifdef PROJ_FM_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         stall_cnt_q <= '0;
      end else if (bus.in_wvalid && !wready && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign bus.out_stall_cnt = stall_cnt_q;
`else
   assign bus.out_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_proj_fm_mbuf.sv
// -----------------------------------------------------------------------------
// tb_proj_fm_mbuf
//   Directed and random stimulus for proj_fm_mbuf, checked every cycle against
//   a queue-based model: closed buffers form a FIFO of (slot, length), and a
//   byte array per slot remembers what was written so stale bytes are known.
// -----------------------------------------------------------------------------
module tb_proj_fm_mbuf;
   import proj_pkg::*;

   localparam int BC  = FM_BUFFER_COUNT;
   localparam int BB  = FM_BUF_BYTES;
   localparam int DB  = FM_GENOME_BTYE;
   localparam int RAC = FM_ADDRESS_READ_COUNT;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   proj_fm_mbuf_if bus ();

   proj_fm_mbuf dut (
      .in_clk   (clk),
      .in_rst_n (rst_n),
      .bus      (bus)
   );

   int total = 0;
   int bad   = 0;

   // reference model
   logic [DB-1:0]    m_mem [BC][BB];
   bit               m_known [BC][BB];
   int               m_slot_q[$];
   int               m_len_q[$];
   int               m_wr_slot;
   int               m_wr_ptr;
   logic [RAC*DB-1:0] m_rdata;
   logic [RAC*DB-1:0] m_rmask;
   bit               m_rvalid;
   int               m_stall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_slot_q.delete();
      m_len_q.delete();
      m_wr_slot = 0;
      m_wr_ptr  = 0;
      m_rdata   = '0;
      m_rmask   = '1;
      m_rvalid  = 0;
      m_stall   = 0;
   endtask

   // Applies the effect of the inputs currently driven, as of the next edge.
   task automatic model_step();
      int fill = m_slot_q.size();
      bit wr_ok = fill < BC;
      m_rvalid = 0;
      if (bus.in_rvalid && fill != 0) begin
         m_rvalid = 1;
         for (int k = 0; k < RAC; k++) begin
            int a = (int'(bus.in_raddr) + k) % BB;
            m_rdata[k*DB +: DB] = m_known[m_slot_q[0]][a] ? m_mem[m_slot_q[0]][a] : '0;
            m_rmask[k*DB +: DB] = m_known[m_slot_q[0]][a] ? '1 : '0;
         end
      end
      if (bus.in_wvalid && wr_ok) begin
         m_mem[m_wr_slot][m_wr_ptr]   = bus.in_wdata;
         m_known[m_wr_slot][m_wr_ptr] = 1;
         if (bus.in_wlast || m_wr_ptr == BB - 1) begin
            m_slot_q.push_back(m_wr_slot);
            m_len_q.push_back(m_wr_ptr + 1);
            m_wr_slot = (m_wr_slot + 1) % BC;
            m_wr_ptr  = 0;
         end else begin
            m_wr_ptr++;
         end
      end
      if (bus.in_wvalid && !wr_ok && m_stall < 65535) m_stall++;
      if (bus.in_rdone && fill != 0) begin
         void'(m_slot_q.pop_front());
         void'(m_len_q.pop_front());
      end
   endtask

   task automatic check_all();
      int exp_stall;
`ifdef PROJ_FM_STALL_CNT_EN
      exp_stall = m_stall;
`else
      exp_stall = 0;
`endif
      chk("wready", 64'(bus.out_wready), 64'(m_slot_q.size() < BC));
      chk("rready", 64'(bus.out_rready), 64'(m_slot_q.size() != 0));
      chk("fill_cnt", 64'(bus.out_fill_cnt), 64'(m_slot_q.size()));
      chk("rlen", 64'(bus.out_rlen), 64'(m_slot_q.size() != 0 ? m_len_q[0] : 0));
      chk("rdata_valid", 64'(bus.out_rdata_valid), 64'(m_rvalid));
      chk("rdata", 64'(bus.out_rdata & m_rmask), 64'(m_rdata & m_rmask));
      chk("stall_cnt", 64'(bus.out_stall_cnt), 64'(exp_stall));
   endtask

   task automatic drive(input bit wv, input logic [DB-1:0] wd, input bit wl,
                        input bit rv, input int ra, input bit rd);
      bus.in_wvalid = wv;
      bus.in_wdata  = wd;
      bus.in_wlast  = wl;
      bus.in_rvalid = rv;
      bus.in_raddr  = fm_addr_t'(ra);
      bus.in_rdone  = rd;
   endtask

   task automatic idle();
      drive(0, '0, 0, 0, 0, 0);
   endtask

   // One clock: model the edge, let it happen, then compare 1 time unit later.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      idle();
      model_reset();

      // reset state
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_all();

      // fill buffer 0 with 0x00..0xFF
      for (int i = 0; i < BB; i++) begin
         drive(1, DB'(i), 0, 0, 0, 0);
         cycle();
      end
      idle();
      chk("fill_after_256", 64'(bus.out_fill_cnt), 64'd1);
      chk("rlen_256", 64'(bus.out_rlen), 64'd256);

      drive(0, '0, 0, 1, 'h10, 0);
      cycle();
      chk("read_0x10", 64'(bus.out_rdata), 64'h13121110);
      idle();
      cycle();

      drive(0, '0, 0, 1, 'hFE, 0);
      cycle();
      chk("read_wrap", 64'(bus.out_rdata), 64'h0100FFFE);
      idle();
      cycle();

      drive(0, '0, 0, 0, 0, 1);
      cycle();
      idle();

      // early close after 10 bytes (slot 1)
      for (int i = 0; i < 10; i++) begin
         drive(1, DB'('hA0 + i), i == 9, 0, 0, 0);
         cycle();
      end
      idle();
      chk("early_fill", 64'(bus.out_fill_cnt), 64'd1);
      chk("early_rlen", 64'(bus.out_rlen), 64'd10);

      // two more full buffers (slots 2, 0) -> back-pressure
      for (int i = 0; i < BB; i++) begin
         drive(1, DB'(i * 7 + 3), 0, 0, 0, 0);
         cycle();
      end
      for (int i = 0; i < BB; i++) begin
         drive(1, DB'(i ^ 'h5A), 0, 0, 0, 0);
         cycle();
      end
      chk("bp_wready_low", 64'(bus.out_wready), 64'd0);
      for (int i = 0; i < 5; i++) cycle();  // offered writes refused
      idle();

      drive(0, '0, 0, 1, 0, 0);
      cycle();
      chk("read_early_buf", 64'(bus.out_rdata), 64'hA3A2A1A0);

      drive(0, '0, 0, 0, 0, 1);
      #1;
      chk("wready_not_comb", 64'(bus.out_wready), 64'd0);
      cycle();
      idle();
      chk("bp_fill_2", 64'(bus.out_fill_cnt), 64'd2);
      chk("bp_wready_high", 64'(bus.out_wready), 64'd1);

      // next buffer began at offset 0
      drive(0, '0, 0, 1, 0, 0);
      cycle();
      chk("read_second_buf", 64'(bus.out_rdata), 64'h18110A03);

      // 4th buffer (slot 1 again), readable after two releases
      for (int i = 0; i < 20; i++) begin
         drive(1, DB'('hC0 + i), i == 19, 0, 0, 0);
         cycle();
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, '0, 0, 0, 0, 1);
         cycle();
      end
      drive(0, '0, 0, 1, 0, 0);
      cycle();
      chk("read_fourth_buf", 64'(bus.out_rdata), 64'hC3C2C1C0);
      chk("fourth_rlen", 64'(bus.out_rlen), 64'd20);

      // close + release + read in the same cycle
      for (int i = 0; i < 9; i++) begin
         drive(1, DB'('h30 + i), 0, 0, 0, 0);
         cycle();
      end
      drive(1, DB'('h39), 1, 1, 4, 1);
      cycle();
      idle();
      chk("simul_fill", 64'(bus.out_fill_cnt), 64'd1);
      chk("simul_read", 64'(bus.out_rdata), 64'hC7C6C5C4);
      chk("simul_rlen", 64'(bus.out_rlen), 64'd10);
      cycle();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 9) < 7, DB'($urandom), $urandom_range(0, 39) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, BB - 1), $urandom_range(0, 19) == 0);
         cycle();
      end
      idle();

      // drain, then reset in the middle of a stream at byte 100
      for (int i = 0; i < BC && m_slot_q.size() != 0; i++) begin
         drive(0, '0, 0, 0, 0, 1);
         cycle();
      end
      for (int i = 0; i < 100; i++) begin
         drive(1, DB'(i), i == 0, i == 99, i, 0);
         cycle();
      end
      chk("pre_reset_rvalid", 64'(bus.out_rdata_valid), 64'd1);
      #1;
      rst_n = 1'b0;
      idle();
      model_reset();
      #1;
      chk("rst_fill", 64'(bus.out_fill_cnt), 64'd0);
      chk("rst_rvalid", 64'(bus.out_rdata_valid), 64'd0);
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_all();

      // three one-byte buffers, then 5 refused cycles
      for (int i = 0; i < BC; i++) begin
         drive(1, DB'('hE0 + i), 1, 0, 0, 0);
         cycle();
      end
      for (int i = 0; i < 5; i++) begin
         drive(1, 8'hEE, 0, 0, 0, 0);
         cycle();
      end
      idle();
`ifdef PROJ_FM_STALL_CNT_EN
      chk("stall_5", 64'(bus.out_stall_cnt), 64'd5);
`else
      chk("stall_off", 64'(bus.out_stall_cnt), 64'd0);
`endif
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/proj_fm_mbuf.md
Name: proj_fm_mbuf

Overview:
- Parametrised multi-buffer feature memory (FM) that succeeds the fixed-rotation FM RAM.
- Genome bytes stream in through a valid/ready handshake and fill the buffers round-robin.
- The consumer reads READ_ADDRESSES_COUNT consecutive bytes from any offset of the oldest full buffer, then releases that buffer explicitly.
- Adds back-pressure, early buffer close (partial length) and full-buffer occupancy tracking; sits between the genome loader and the minhash window logic.

Parameters:
- BUFFER_COUNT, 3, number of buffers in rotation (>=2).
- RAMS, 4, RAM banks per buffer.
- ENTRIES, 16, entries per RAM.
- OFFSET, 4, bytes per entry.
- DATA_BITS, 8, width of one genome byte.
- READ_ADDRESSES_COUNT, 4, bytes returned per read (<= RAMS*ENTRIES*OFFSET).
- Derived: BUF_BYTES = RAMS*ENTRIES*OFFSET (default 256); AW = $clog2(BUF_BYTES); CW = $clog2(BUFFER_COUNT+1).

Ports:
- in_clk  input  1  clock, all logic on rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_wvalid  input  1  write byte valid.
- in_wdata  input  DATA_BITS  byte to write.
- in_wlast  input  1  with accepted write: this byte closes the current buffer.
- out_wready  output  1  writer may transfer.
- in_rvalid  input  1  read request.
- in_raddr  input  AW  start byte offset inside the head buffer.
- out_rready  output  1  a full buffer is available to read.
- out_rdata  output  READ_ADDRESSES_COUNT*DATA_BITS  read window; byte k at bits [k*DATA_BITS +: DATA_BITS].
- out_rdata_valid  output  1  out_rdata valid this cycle.
- out_rlen  output  AW+1  valid byte count of the head buffer (1..BUF_BYTES).
- in_rdone  input  1  release the head buffer.
- out_fill_cnt  output  CW  number of full, unreleased buffers.
- out_stall_cnt  output  16  write-stall counter (see Optional Feature).

Behaviour:
- Reset values:
  - Internal state: wr_idx, rd_idx, wr_ptr, fill_cnt = 0.
  - Outputs: out_rdata_valid=0, out_rdata=0, out_rlen=0, out_stall_cnt=0.
  - RAM contents are not cleared.
- Reset mid-operation: all pointers return to 0 immediately (asynchronous); any in-flight read result is dropped.
- Write acceptance:
  - out_wready = (fill_cnt < BUFFER_COUNT), purely combinational from registered fill_cnt.
  - A write is accepted when in_wvalid && out_wready; the byte is stored at buffer wr_idx, offset wr_ptr.
- Buffer close:
  - A buffer closes on the accepted byte where wr_ptr==BUF_BYTES-1 or in_wlast=1.
  - On close: len[wr_idx] <= wr_ptr+1; wr_ptr <= 0; wr_idx <= (wr_idx+1) mod BUFFER_COUNT; fill_cnt increments.
  - Otherwise wr_ptr increments.
- Read request:
  - out_rready = (fill_cnt != 0). A read is accepted when in_rvalid && out_rready; otherwise it is ignored.
  - Latency 1: on the next cycle out_rdata_valid=1 and out_rdata holds bytes (in_raddr+k) mod BUF_BYTES, k=0..READ_ADDRESSES_COUNT-1, from buffer rd_idx.
  - Bytes beyond out_rlen return stale contents; no masking.
- Read output hold: out_rdata holds its value when no read is accepted. out_rdata_valid is a 1-cycle pulse per accepted read; back-to-back reads give one result per cycle.
- Release:
  - in_rdone with fill_cnt!=0 sets rd_idx <= (rd_idx+1) mod BUFFER_COUNT and decrements fill_cnt.
  - in_rdone with fill_cnt==0 is ignored.
  - A read and in_rdone in the same cycle: the read uses the pre-release rd_idx.
- Simultaneous close and release: fill_cnt is unchanged and both indices advance.
- Back-pressure:
  - The writer cannot close into a buffer that is still held: with fill_cnt==BUFFER_COUNT, out_wready=0.
  - A release in that cycle raises out_wready in the following cycle, not combinationally.
- out_rlen = len[rd_idx] when fill_cnt!=0, else 0.
- Bank mapping: byte address a lives in RAM (a / (ENTRIES*OFFSET)), entry (a / OFFSET) mod ENTRIES, lane a mod OFFSET.
  - The read window may span RAM boundaries and the buffer wrap; the read mux handles both.

Optional Feature:
- Macro PROJ_FM_STALL_CNT_EN.
- Defined: out_stall_cnt increments each cycle in_wvalid=1 && out_wready=0. It saturates at 16'hFFFF and clears only on reset.
- Undefined: out_stall_cnt is tied to 0 and no counter flops are generated.

Decomposition:
- proj_pkg gains FM_BUFFER_COUNT, FM_RAMS_COUNT, FM_ENTRIES_COUNT, FM_OFFSET_COUNT, FM_GENOME_BTYE and FM_ADDRESS_READ_COUNT (or reuses them where they already exist).
- proj_pkg also gains fm_addr_t (AW bits) and fm_len_t (AW+1 bits).
- One sub-module, proj_fm_buf_bank: a single buffer's byte-write port plus a READ_ADDRESSES_COUNT-wide wrapped read. It is instantiated BUFFER_COUNT times, and the top level muxes the banks by rd_idx.

Test Plan:
- Fill: reset, stream bytes 0x00..0xFF with in_wvalid=1 -> after byte 255, out_fill_cnt=1 and out_rlen=256. Read raddr=0x10 -> next cycle rdata bytes 0x10,0x11,0x12,0x13.
- Wrap read: raddr=0xFE on the full buffer -> bytes 0xFE,0xFF,0x00,0x01.
- Early close: write 10 bytes with in_wlast on the 10th -> out_fill_cnt=1, out_rlen=10; the next buffer starts at wr_ptr=0.
- Back-pressure: fill 3 buffers with no release -> out_wready=0. Pulse in_rdone -> out_fill_cnt=2 and out_wready=1 in the next cycle; the 4th buffer's data is readable after the following release.
- Simultaneous events: last byte of buffer 1 plus in_rdone plus read in the same cycle -> fill_cnt unchanged, and the read returns buffer 0 data.
- Reset mid-stream at byte 100 -> out_fill_cnt=0, out_rdata_valid=0; with PROJ_FM_STALL_CNT_EN, 5 stalled cycles give out_stall_cnt=5.
